mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access pipeline stage, directly downstream of the execute stage.
- Registers the EX→MEM bundle: pc, RAM enable/write-enable, result select, RF write info, ALU result, load-type flags, byte select and the HI/LO write bundle.
- Takes the synchronous data SRAM read data that returns in this cycle and extracts/extends the byte, half or word for loads.
- Drives the MEM→WB bundle, the MEM→RF forwarding bundle and the HI/LO forwarding bundle.
- Holds the captured load data stable across stalls.

Parameters:
EX_TO_MEM_WD, 76, width of ex_to_mem_bus {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
MEM_TO_WB_WD, 70, width of mem_to_wb_bus {pc[69:38], rf_we[37], rf_waddr[36:32], mem_result[31:0]}
MEM_TO_RF_WD, 38, width of mem_to_rf_bus {rf_we[37], rf_waddr[36:32], mem_result[31:0]}
LOAD_W, 5, load-type one-hot {lb, lbu, lh, lhu, lw}
HILO_W, 66, {hi_we, lo_we, hi_wdata[63:32], lo_wdata[31:0]}

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  6  pipeline stall vector; bit3 = EX/MEM register, bit4 = MEM/WB; 1 = Stop
ex_to_mem_bus  in  76  EX result bundle
ex_load_bus  in  5  load-type one-hot from EX
ex_data_ram_sel  in  4  byte-lane select from EX
ex_hi_lo_bus  in  66  HI/LO write bundle from EX
data_sram_rdata  in  32  SRAM read data; valid the cycle after the EX address
mem_to_wb_bus  out  70  bundle to WB
mem_to_rf_bus  out  38  forwarding bundle to ID
mem_hi_lo_bus  out  66  HI/LO bundle to WB and ID forwarding
mem_is_load  out  1  registered instruction is a load (sel_rf_res); used for the load-use hazard

Behaviour:
- Reset: rst is synchronous and active-high; the clock is clk. All internal registers clear to 0 on rst. All outputs are therefore 0 (rf_we=0, hi_we=lo_we=0, mem_is_load=0) from the first edge with rst high.
- Input register update, evaluated in priority order each posedge:
  - rst: clear.
  - stall[3]=1 and stall[4]=0: insert a bubble (all fields 0).
  - stall[3]=0: capture ex_to_mem_bus, ex_load_bus, ex_data_ram_sel, ex_hi_lo_bus.
  - Otherwise: hold.
- Read-data hold register rd_hold plus flag rd_valid:
  - Set: on a posedge where the registered instruction is a load (sel_rf_res=1), stall[4]=1 and rd_valid=0, load rd_hold ← data_sram_rdata and set rd_valid.
  - Clear: rd_valid clears whenever the input register captures or bubbles, and on rst.
  - Data source: rd_eff = rd_valid ? rd_hold : data_sram_rdata.
  - Purpose: the SRAM output is overwritten by the addresses EX keeps issuing during a stall.
- Load extraction is combinational from rd_eff, the registered sel and the load flags:
  - lb/lbu, sel one-hot: 0001→[7:0], 0010→[15:8], 0100→[23:16], 1000→[31:24]. lb sign-extends from bit 7 of the chosen byte; lbu zero-extends.
  - lh/lhu: sel 0011→[15:0], 1100→[31:16]. lh sign-extends; lhu zero-extends.
  - lw: sel 1111→rd_eff.
  - Any other sel or flag combination: load_data=0.
- mem_result = sel_rf_res ? load_data : ex_result.
- Stores: rf_we is 0 from EX, so nothing is written back; they pass through as pc only.
- mem_to_wb_bus = {pc, rf_we, rf_waddr, mem_result}. mem_to_rf_bus = {rf_we, rf_waddr, mem_result}. Both are combinational from the registers and rd_eff; there is no extra latency.
- mem_hi_lo_bus is the registered ex_hi_lo_bus, unchanged.
- Latency: an EX instruction appears on the outputs one cycle after capture.
- Simultaneous events:
  - rst overrides stall.
  - Bubble plus pending rd_valid: rd_valid clears.
  - stall[3]=stall[4]=1 for N cycles: outputs are constant for all N cycles.
- Reset mid-operation: a held load is discarded; outputs are 0 on the next cycle.

Test Plan:
- Reset: assert rst 2 cycles with nonzero inputs → all outputs 0, mem_is_load=0.
- Plain ALU pass: ex_to_mem_bus pc=0xBFC00010, rf_we=1, waddr=5, result=0x1234 → next cycle mem_to_wb_bus carries pc 0xBFC00010, we 1, waddr 5, result 0x00001234.
- Load extension with rdata=0x80F17F82:
  - lb sel=0001 → 0xFFFFFF82
  - lbu sel=0010 → 0x0000007F
  - lh sel=1100 → 0xFFFF80F1
  - lhu sel=0011 → 0x00007F82
  - lw → 0x80F17F82
- Stall hold: lw captured with rdata=0xDEADBEEF, then stall[4:3]=11 for 3 cycles while rdata changes to 0x11111111 → mem_result stays 0xDEADBEEF throughout.
- Bubble: stall[3]=1, stall[4]=0 with a valid EX instruction → next cycle rf_we=0, pc=0, hi_we=lo_we=0.
- HI/LO pass: ex_hi_lo_bus with hi_we=1, lo_we=1, hi=0x1, lo=0x2 → identical mem_hi_lo_bus one cycle later.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX bundle, extracts load data
// from the synchronous data SRAM and drives the WB, forwarding and HI/LO buses.
module mem_stage #(
  parameter int unsigned EX_TO_MEM_WD = 76,
  parameter int unsigned MEM_TO_WB_WD = 70,
  parameter int unsigned MEM_TO_RF_WD = 38,
  parameter int unsigned LOAD_W       = 5,
  parameter int unsigned HILO_W       = 66
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [LOAD_W-1:0]       ex_load_bus,
  input  logic [3:0]              ex_data_ram_sel,
  input  logic [HILO_W-1:0]       ex_hi_lo_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
  output logic [HILO_W-1:0]       mem_hi_lo_bus,
  output logic                    mem_is_load
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned SEL_W  = 4;

  // One-hot load-type encodings {lb, lbu, lh, lhu, lw}
  localparam logic [LOAD_W-1:0] LD_LB  = LOAD_W'(5'b10000);
  localparam logic [LOAD_W-1:0] LD_LBU = LOAD_W'(5'b01000);
  localparam logic [LOAD_W-1:0] LD_LH  = LOAD_W'(5'b00100);
  localparam logic [LOAD_W-1:0] LD_LHU = LOAD_W'(5'b00010);
  localparam logic [LOAD_W-1:0] LD_LW  = LOAD_W'(5'b00001);

  // Pipeline register contents
  logic [EX_TO_MEM_WD-1:0] ex_r;
  logic [LOAD_W-1:0]       load_r;
  logic [SEL_W-1:0]        sel_r;
  logic [HILO_W-1:0]       hilo_r;

  // Captured SRAM read data for loads stalled in MEM
  logic [DATA_W-1:0]       rd_hold;
  logic                    rd_valid;

  // Decoded fields of the registered EX bundle
  logic [31:0]             pc;
  logic                    ram_en;
  logic [3:0]              ram_wen;
  logic                    sel_rf_res;
  logic                    rf_we;
  logic [ADDR_W-1:0]       rf_waddr;
  logic [DATA_W-1:0]       ex_result;

  logic                    do_bubble;
  logic                    do_capture;
  logic [DATA_W-1:0]       rd_eff;
  logic [DATA_W-1:0]       load_data;
  logic [DATA_W-1:0]       mem_result;
  logic                    unused_bits;

  assign pc         = ex_r[75:44];
  assign ram_en     = ex_r[43];
  assign ram_wen    = ex_r[42:39];
  assign sel_rf_res = ex_r[38];
  assign rf_we      = ex_r[37];
  assign rf_waddr   = ex_r[36:32];
  assign ex_result  = ex_r[31:0];

  // Memory-side controls and unrelated stall bits are consumed upstream
  assign unused_bits = ^{ram_en, ram_wen, stall[5], stall[2:0]};

  assign do_bubble  = stall[3] & ~stall[4];
  assign do_capture = ~stall[3];

  // EX/MEM input register: bubble, capture or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r   <= '0;
      load_r <= '0;
      sel_r  <= '0;
      hilo_r <= '0;
    end else if (do_bubble) begin
      ex_r   <= '0;
      load_r <= '0;
      sel_r  <= '0;
      hilo_r <= '0;
    end else if (do_capture) begin
      ex_r   <= ex_to_mem_bus;
      load_r <= ex_load_bus;
      sel_r  <= ex_data_ram_sel;
      hilo_r <= ex_hi_lo_bus;
    end
  end

  // Freeze the load's SRAM data on the first stalled cycle; EX keeps
  // issuing addresses during a stall and would overwrite the SRAM output.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_hold  <= '0;
      rd_valid <= 1'b0;
    end else if (do_bubble || do_capture) begin
      rd_valid <= 1'b0;
    end else if (sel_rf_res && stall[4] && !rd_valid) begin
      rd_hold  <= data_sram_rdata;
      rd_valid <= 1'b1;
    end
  end

  assign rd_eff = rd_valid ? rd_hold : data_sram_rdata;

  // Byte/half/word extraction with sign or zero extension
  always_comb begin
    load_data = '0;
    case (load_r)
      LD_LB, LD_LBU: begin
        case (sel_r)
          4'b0001: load_data = {{24{(load_r == LD_LB) & rd_eff[7]}},  rd_eff[7:0]};
          4'b0010: load_data = {{24{(load_r == LD_LB) & rd_eff[15]}}, rd_eff[15:8]};
          4'b0100: load_data = {{24{(load_r == LD_LB) & rd_eff[23]}}, rd_eff[23:16]};
          4'b1000: load_data = {{24{(load_r == LD_LB) & rd_eff[31]}}, rd_eff[31:24]};
          default: load_data = '0;
        endcase
      end
      LD_LH, LD_LHU: begin
        case (sel_r)
          4'b0011: load_data = {{16{(load_r == LD_LH) & rd_eff[15]}}, rd_eff[15:0]};
          4'b1100: load_data = {{16{(load_r == LD_LH) & rd_eff[31]}}, rd_eff[31:16]};
          default: load_data = '0;
        endcase
      end
      LD_LW: begin
        if (sel_r == 4'b1111) load_data = rd_eff;
      end
      default: load_data = '0;
    endcase
  end

  assign mem_result = sel_rf_res ? load_data : ex_result;

  // Output bundles, combinational from the stage registers and read data
  assign mem_to_wb_bus = {pc, rf_we, rf_waddr, mem_result};
  assign mem_to_rf_bus = {rf_we, rf_waddr, mem_result};
  assign mem_hi_lo_bus = hilo_r;
  assign mem_is_load   = sel_rf_res;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [75:0] ex_to_mem_bus;
  logic [4:0]  ex_load_bus;
  logic [3:0]  ex_data_ram_sel;
  logic [65:0] ex_hi_lo_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;
  logic [65:0] mem_hi_lo_bus;
  logic        mem_is_load;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_load_bus     (ex_load_bus),
    .ex_data_ram_sel (ex_data_ram_sel),
    .ex_hi_lo_bus    (ex_hi_lo_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_rf_bus   (mem_to_rf_bus),
    .mem_hi_lo_bus   (mem_hi_lo_bus),
    .mem_is_load     (mem_is_load)
  );

  function automatic logic [75:0] mk_ex(input logic [31:0] pc, input logic ld,
                                        input logic we, input logic [4:0] wa,
                                        input logic [31:0] res);
    return {pc, ld, 4'b0000, ld, we, wa, res};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [4:0] ld, input logic [3:0] sel);
    ex_to_mem_bus   = mk_ex(32'hBFC00100, 1'b1, 1'b1, 5'd8, 32'h00001000);
    ex_load_bus     = ld;
    ex_data_ram_sel = sel;
  endtask

  initial begin
    // Reset with nonzero inputs
    rst             = 1'b1;
    stall           = 6'b000000;
    ex_to_mem_bus   = mk_ex(32'hBFC00000, 1'b1, 1'b1, 5'd3, 32'hCAFEF00D);
    ex_load_bus     = 5'b00001;
    ex_data_ram_sel = 4'b1111;
    ex_hi_lo_bus    = {1'b1, 1'b1, 32'h55, 32'h66};
    data_sram_rdata = 32'h87654321;
    tick();
    tick();
    chk("reset_wb",   70'(mem_to_wb_bus), 70'd0);
    chk("reset_rf",   70'(mem_to_rf_bus), 70'd0);
    chk("reset_hilo", 70'(mem_hi_lo_bus[65:32]), 70'd0);
    chk("reset_is_load", 70'(mem_is_load), 70'd0);

    // Plain ALU pass-through
    rst           = 1'b0;
    ex_to_mem_bus = mk_ex(32'hBFC00010, 1'b0, 1'b1, 5'd5, 32'h00001234);
    ex_load_bus   = 5'b00000;
    ex_data_ram_sel = 4'b0000;
    ex_hi_lo_bus  = '0;
    tick();
    chk("alu_wb", 70'(mem_to_wb_bus), {32'hBFC00010, 1'b1, 5'd5, 32'h00001234});
    chk("alu_rf", 70'(mem_to_rf_bus), 70'({1'b1, 5'd5, 32'h00001234}));
    chk("alu_is_load", 70'(mem_is_load), 70'd0);

    // Load extraction from rdata = 80F17F82
    data_sram_rdata = 32'h80F17F82;
    drive_load(5'b10000, 4'b0001); tick();
    chk("lb_b0",  70'(mem_to_wb_bus[31:0]), 70'(32'hFFFFFF82));
    chk("lb_is_load", 70'(mem_is_load), 70'd1);
    drive_load(5'b01000, 4'b0010); tick();
    chk("lbu_b1", 70'(mem_to_wb_bus[31:0]), 70'(32'h0000007F));
    drive_load(5'b00100, 4'b1100); tick();
    chk("lh_hi",  70'(mem_to_wb_bus[31:0]), 70'(32'hFFFF80F1));
    drive_load(5'b00010, 4'b0011); tick();
    chk("lhu_lo", 70'(mem_to_wb_bus[31:0]), 70'(32'h00007F82));
    drive_load(5'b00001, 4'b1111); tick();
    chk("lw",     70'(mem_to_wb_bus[31:0]), 70'(32'h80F17F82));
    chk("lw_rf",  70'(mem_to_rf_bus), 70'({1'b1, 5'd8, 32'h80F17F82}));
    drive_load(5'b10000, 4'b1000); tick();
    chk("lb_b3",  70'(mem_to_wb_bus[31:0]), 70'(32'hFFFFFF80));
    drive_load(5'b01000, 4'b0100); tick();
    chk("lbu_b2", 70'(mem_to_wb_bus[31:0]), 70'(32'h000000F1));
    drive_load(5'b00001, 4'b0011); tick();
    chk("lw_badsel", 70'(mem_to_wb_bus[31:0]), 70'd0);
    drive_load(5'b10000, 4'b0011); tick();
    chk("lb_badsel", 70'(mem_to_wb_bus[31:0]), 70'd0);
    drive_load(5'b11000, 4'b0001); tick();
    chk("multi_flag", 70'(mem_to_wb_bus[31:0]), 70'd0);

    // Stall hold: data captured on first stalled edge survives rdata changes
    drive_load(5'b00001, 4'b1111);
    data_sram_rdata = 32'h00000000;
    tick();
    data_sram_rdata = 32'hDEADBEEF;
    stall = 6'b011000;
    #1;
    chk("hold_c0", 70'(mem_to_wb_bus[31:0]), 70'(32'hDEADBEEF));
    for (int i = 0; i < 3; i++) begin
      tick();
      data_sram_rdata = 32'h11111111;
      #1;
      chk("hold_wb", 70'(mem_to_wb_bus), {32'hBFC00100, 1'b1, 5'd8, 32'hDEADBEEF});
    end

    // Bubble while a held load is pending: everything clears
    ex_to_mem_bus = mk_ex(32'hBFC00200, 1'b0, 1'b1, 5'd9, 32'h0000ABCD);
    ex_hi_lo_bus  = {1'b1, 1'b1, 32'h7, 32'h8};
    stall = 6'b001000;
    tick();
    chk("bubble_wb",   70'(mem_to_wb_bus), 70'd0);
    chk("bubble_hilo", 70'(mem_hi_lo_bus[65:64]), 70'd0);
    chk("bubble_is_load", 70'(mem_is_load), 70'd0);

    // Fresh load after bubble reads live SRAM data
    stall = 6'b000000;
    drive_load(5'b00001, 4'b1111);
    tick();
    data_sram_rdata = 32'h0BADF00D;
    #1;
    chk("post_bubble_lw", 70'(mem_to_wb_bus[31:0]), 70'(32'h0BADF00D));

    // HI/LO pass-through
    ex_to_mem_bus = mk_ex(32'hBFC00300, 1'b0, 1'b0, 5'd0, 32'h0);
    ex_hi_lo_bus  = {1'b1, 1'b1, 32'h00000001, 32'h00000002};
    tick();
    chk("hilo_pass", 70'(mem_hi_lo_bus), 70'({1'b1, 1'b1, 32'h00000001, 32'h00000002}));
    chk("store_like_rf_we", 70'(mem_to_rf_bus[37]), 70'd0);

    // Reset mid-operation discards a held load
    drive_load(5'b00001, 4'b1111);
    ex_hi_lo_bus = '0;
    tick();
    data_sram_rdata = 32'h22222222;
    stall = 6'b011000;
    tick();
    data_sram_rdata = 32'h33333333;
    #1;
    chk("pre_rst_hold", 70'(mem_to_wb_bus[31:0]), 70'(32'h22222222));
    rst = 1'b1;
    tick();
    chk("mid_rst_wb", 70'(mem_to_wb_bus), 70'd0);
    rst   = 1'b0;
    stall = 6'b000000;
    tick();
    data_sram_rdata = 32'h12345678;
    #1;
    chk("after_rst_lw", 70'(mem_to_wb_bus[31:0]), 70'(32'h12345678));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
